index_to_mask: RTL and testbench

//  Inverse of the lowest-set-bit log2 encoder. Collects a frame of bit indices over
//  a valid/ready stream and builds the one-hot/multi-hot vector they describe.

---
 rtl/index_to_mask.sv | 100 ++++++++++
 tb/tb_index_to_mask.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/index_to_mask.sv
// Rebuilds a multi-hot vector from a valid/ready stream of bit indices, one result per frame.
// A frame ends on an inLast beat; the result is held until the consumer takes it.
module index_to_mask #(
    parameter int IDX_W = 3,
    parameter int VEC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [IDX_W-1:0] inIndex,
    input  logic             inLast,
    output logic             outValid,
    input  logic             outReady,
    output logic [VEC_W-1:0] outVector,
    output logic [IDX_W:0]   outCount,
    output logic             outError
);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [VEC_W-1:0] mask_reg, mask_next;
    logic [IDX_W:0]   count_reg, count_next;
    logic             err_reg, err_next;
    logic [VEC_W-1:0] hit;
    logic             accept;
    logic             is_new;
    logic             release_frame;

    // One-hot decode of the index; an all-zero hit means the index is out of range.
    generate
        for (genvar gi = 0; gi < VEC_W; gi++) begin : g_decode
            assign hit[gi] = (inIndex == IDX_W'(gi));
        end
    endgenerate

    assign accept        = inValid && inReady;
    assign is_new        = |(hit & ~mask_reg);
    assign release_frame = (state_reg == HOLD) && outReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (accept && inLast) state_next = HOLD;
            HOLD:    if (outReady)         state_next = COLLECT;
            default:                       state_next = COLLECT;
        endcase
    end

    always_comb begin
        inReady  = rst_n && (state_reg == COLLECT);
        outValid = (state_reg == HOLD);
    end

    // Duplicates and out-of-range indices leave mask and count alone, so the
    // count can never exceed VEC_W.
    always_comb begin
        mask_next  = mask_reg;
        count_next = count_reg;
        err_next   = err_reg;
        if (release_frame) begin
            mask_next  = '0;
            count_next = '0;
            err_next   = 1'b0;
        end else if (accept) begin
            if (is_new) begin
                mask_next  = mask_reg | hit;
                count_next = count_reg + 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            mask_reg  <= mask_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    assign outVector = mask_reg;
    assign outCount  = count_reg;
    assign outError  = err_reg;

endmodule

// File: tb/tb_index_to_mask.sv
// Directed bench for index_to_mask: default 3/8 instance plus a 3/6 instance for range errors.
module tb_index_to_mask;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_valid, a_ready, a_last, a_ovalid, a_oready, a_err;
    logic [2:0] a_index;
    logic [7:0] a_vec;
    logic [3:0] a_cnt;

    logic       b_valid, b_ready, b_last, b_ovalid, b_oready, b_err;
    logic [2:0] b_index;
    logic [5:0] b_vec;
    logic [3:0] b_cnt;

    int vectors = 0;
    int miscompares = 0;

    index_to_mask #(.IDX_W(3), .VEC_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .inValid(a_valid), .inReady(a_ready), .inIndex(a_index), .inLast(a_last),
        .outValid(a_ovalid), .outReady(a_oready),
        .outVector(a_vec), .outCount(a_cnt), .outError(a_err)
    );

    index_to_mask #(.IDX_W(3), .VEC_W(6)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .inValid(b_valid), .inReady(b_ready), .inIndex(b_index), .inLast(b_last),
        .outValid(b_ovalid), .outReady(b_oready),
        .outVector(b_vec), .outCount(b_cnt), .outError(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Presents one beat and returns 1ns after the edge that accepted it.
    task automatic send(input bit use_b, input logic [2:0] idx, input bit last);
        bit ok;
        ok = 1'b0;
        if (use_b) begin b_valid = 1'b1; b_index = idx; b_last = last; end
        else       begin a_valid = 1'b1; a_index = idx; a_last = last; end
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = use_b ? b_ready : a_ready;
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic take_a();
        a_oready = 1'b1;
        @(posedge clk);
        #1;
        a_oready = 1'b0;
        chk("take_outValid", a_ovalid, 0);
        chk("take_inReady", a_ready, 1);
        chk("take_cleared", a_vec, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = 0; a_index = 0; a_last = 0; a_oready = 0;
        b_valid = 0; b_index = 0; b_last = 0; b_oready = 0;
        #2;
        chk("rst_inReady", a_ready, 0);
        chk("rst_outValid", a_ovalid, 0);
        chk("rst_outVector", a_vec, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a frame discards it.
        send(0, 3'd1, 0);
        send(0, 3'd4, 0);
        chk("mid_partial_vec", a_vec, 8'h12);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vec", a_vec, 8'h00);
        chk("mid_rst_cnt", a_cnt, 0);
        chk("mid_rst_err", a_err, 0);
        chk("mid_rst_valid", a_ovalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 3'd2, 1);
        chk("after_rst_valid", a_ovalid, 1);
        chk("after_rst_vec", a_vec, 8'h04);
        chk("after_rst_cnt", a_cnt, 1);
        take_a();

        // outReady held high: result lives for exactly one cycle.
        a_oready = 1'b1;
        send(0, 3'd0, 0);
        send(0, 3'd3, 0);
        send(0, 3'd7, 1);
        chk("f089_valid", a_ovalid, 1);
        chk("f089_vec", a_vec, 8'h89);
        chk("f089_cnt", a_cnt, 3);
        chk("f089_err", a_err, 0);
        @(posedge clk);
        #1;
        a_oready = 1'b0;
        chk("f089_valid_drop", a_ovalid, 0);

        // Duplicate index.
        send(0, 3'd5, 0);
        send(0, 3'd5, 0);
        send(0, 3'd1, 1);
        chk("dup_vec", a_vec, 8'h22);
        chk("dup_cnt", a_cnt, 2);
        chk("dup_err", a_err, 1);
        take_a();

        // Backpressure: result held, pending beat refused.
        send(0, 3'd6, 1);
        a_valid = 1'b1;
        a_index = 3'd3;
        a_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", a_ovalid, 1);
            chk("bp_vec", a_vec, 8'h40);
            chk("bp_inReady", a_ready, 0);
        end
        chk("bp_cnt", a_cnt, 1);
        a_oready = 1'b1;
        @(posedge clk);
        #1;
        a_oready = 1'b0;
        a_valid  = 1'b0;
        chk("bp_release_valid", a_ovalid, 0);
        chk("bp_release_inReady", a_ready, 1);
        chk("bp_release_vec", a_vec, 8'h00);

        // Full mask plus one duplicate.
        for (int i = 0; i < 8; i++) send(0, 3'(i), 0);
        send(0, 3'd7, 1);
        chk("full_vec", a_vec, 8'hFF);
        chk("full_cnt", a_cnt, 8);
        chk("full_err", a_err, 1);
        take_a();

        // Out-of-range indices on the narrow instance.
        send(1, 3'd2, 0);
        send(1, 3'd6, 0);
        send(1, 3'd7, 1);
        chk("range_valid", b_ovalid, 1);
        chk("range_vec", b_vec, 6'h04);
        chk("range_cnt", b_cnt, 1);
        chk("range_err", b_err, 1);
        b_oready = 1'b1;
        @(posedge clk);
        #1;
        b_oready = 1'b0;
        chk("range_release", b_ovalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
